// File: rtl/sha3_block_padder.sv
// sha3_block_padder: packs a 64-bit little-endian word stream into rate-sized SHA-3 blocks with multi-rate padding.
// Define SHA3_PADDER_SHAKE_EN to add the xof port (0x1F suffix, SHAKE128 rate in mode 11, BLK_W = 1344).
module sha3_block_padder #(
  parameter int W = 64,
`ifdef SHA3_PADDER_SHAKE_EN
  parameter int BLK_W = 1344
`else
  parameter int BLK_W = 1152
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
`ifdef SHA3_PADDER_SHAKE_EN
  input  logic             xof,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_last,
  input  logic [3:0]       in_bytes,
  output logic             blk_valid,
  input  logic             blk_ready,
  output logic [BLK_W-1:0] blk_data,
  output logic             blk_last,
  output logic [7:0]       blk_cnt,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1; a source
  // holding valid must keep its payload stable until that edge, and ready never depends on valid.

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_EMIT = 2'd1,
    S_PAD  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [4:0]       idx;
  logic [4:0]       rate_r;
  logic [7:0]       sfx_r;
  logic             in_msg;
  logic             pend_pad;
  logic             in_ready_r;
  logic             blk_last_r;
  logic [7:0]       cnt;
  logic [BLK_W-1:0] blk_buf;

  logic             xof_i;
  logic             first;
  logic [4:0]       cur_rate;
  logic [7:0]       cur_sfx;
  logic             hs;
  logic [3:0]       b_sat;
  logic [W-1:0]     word_m;
  logic [7:0]       pos;
  logic [7:0]       rate_bytes;
  logic             exact;
  logic [BLK_W-1:0] fill_blk;
  logic [BLK_W-1:0] pad_blk;

`ifdef SHA3_PADDER_SHAKE_EN
  assign xof_i = xof;
`else
  assign xof_i = 1'b0;
`endif

  function automatic logic [4:0] rate_of(input logic [1:0] m, input logic x);
    case (m)
      2'b00:   rate_of = 5'd9;
      2'b01:   rate_of = 5'd13;
      2'b11:   rate_of = x ? 5'd21 : 5'd17;
      default: rate_of = 5'd18;
    endcase
  endfunction

  // Mode and suffix are taken live only for the opening word of a message, latched copies otherwise.
  assign first    = (idx == 5'd0) && !in_msg;
  assign cur_rate = first ? rate_of(mode, xof_i) : rate_r;
  assign cur_sfx  = first ? (xof_i ? 8'h1F : 8'h06) : sfx_r;
  assign hs       = in_valid && in_ready_r && (state == S_FILL);

  always_comb begin
    b_sat      = (in_bytes > 4'd8) ? 4'd8 : in_bytes;
    word_m     = '0;
    for (int k = 0; k < 8; k++) begin
      word_m[8*k +: 8] = (in_last && (4'(k) >= b_sat)) ? 8'h00 : in_data[8*k +: 8];
    end
    pos        = {idx, 3'b000} + {4'b0000, b_sat};
    rate_bytes = {cur_rate, 3'b000};
    exact      = (pos == rate_bytes);

    fill_blk = blk_buf;
    fill_blk[{idx, 6'b000000} +: W] = word_m;
    if (in_last && !exact) begin
      fill_blk[{pos, 3'b000} +: 8] = fill_blk[{pos, 3'b000} +: 8] ^ cur_sfx;
      fill_blk[{rate_bytes, 3'b000} - 11'd8 +: 8] =
        fill_blk[{rate_bytes, 3'b000} - 11'd8 +: 8] ^ 8'h80;
    end

    pad_blk = '0;
    pad_blk[7:0] = sfx_r;
    pad_blk[{rate_r, 6'b000000} - 11'd8 +: 8] = 8'h80;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FILL: begin
        if (hs && (in_last || (idx + 5'd1 == cur_rate))) state_nxt = S_EMIT;
      end
      S_EMIT: begin
        if (blk_ready) state_nxt = pend_pad ? S_PAD : S_FILL;
      end
      S_PAD:   state_nxt = S_EMIT;
      default: state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_FILL;
      idx        <= '0;
      rate_r     <= 5'd9;
      sfx_r      <= 8'h06;
      in_msg     <= 1'b0;
      pend_pad   <= 1'b0;
      in_ready_r <= 1'b0;
      blk_last_r <= 1'b0;
      cnt        <= '0;
      blk_buf    <= '0;
    end else begin
      state      <= state_nxt;
      in_ready_r <= (state_nxt == S_FILL);
      case (state)
        S_FILL: begin
          if (hs) begin
            blk_buf <= fill_blk;
            idx     <= idx + 5'd1;
            in_msg  <= 1'b1;
            rate_r  <= cur_rate;
            sfx_r   <= cur_sfx;
            if (state_nxt == S_EMIT) begin
              cnt        <= cnt + 8'd1;
              blk_last_r <= in_last && !exact;
              pend_pad   <= in_last && exact;
            end
          end
        end
        S_EMIT: begin
          if (blk_ready) begin
            blk_buf    <= '0;
            idx        <= '0;
            blk_last_r <= 1'b0;
            if (blk_last_r) begin
              cnt    <= '0;
              in_msg <= 1'b0;
            end
          end
        end
        S_PAD: begin
          blk_buf    <= pad_blk;
          blk_last_r <= 1'b1;
          pend_pad   <= 1'b0;
          cnt        <= cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign blk_valid = (state == S_EMIT);
  assign blk_data  = blk_buf;
  assign blk_last  = blk_last_r;
  assign blk_cnt   = cnt;
  assign dbg_state = state;

endmodule

// File: tb/tb_sha3_block_padder.sv
// Bench for sha3_block_padder: directed reset/latency/backpressure steps plus random messages against a byte-level pad model.
module tb_sha3_block_padder;
  localparam int W     = 64;
  localparam int BLK_W = 1152;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       mode;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             in_last;
  logic [3:0]       in_bytes;
  logic             blk_valid;
  logic             blk_ready;
  logic [BLK_W-1:0] blk_data;
  logic             blk_last;
  logic [7:0]       blk_cnt;
  logic [1:0]       dbg_state;

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0]       msg_q[$];
  logic [BLK_W-1:0] exp_q[$];
  logic             exp_last_q[$];
  logic [7:0]       exp_cnt_q[$];

  sha3_block_padder dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_bytes  (in_bytes),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_last  (blk_last),
    .blk_cnt   (blk_cnt),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not end, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic int rate_bytes(input logic [1:0] m);
    case (m)
      2'b00:   return 72;
      2'b01:   return 104;
      2'b11:   return 136;
      default: return 144;
    endcase
  endfunction

  // Reference: msg || 0x06 || 0* || 0x80 (0x06^0x80 when one byte), cut into rate-sized blocks.
  function automatic void model_msg(input logic [1:0] m);
    int               r;
    int               nblk;
    logic [7:0]       p[$];
    logic [BLK_W-1:0] blk;
    r = rate_bytes(m);
    p = msg_q;
    p.push_back(8'h06);
    while (p.size() % r != 0) p.push_back(8'h00);
    p[p.size()-1] = p[p.size()-1] ^ 8'h80;
    nblk = p.size() / r;
    for (int i = 0; i < nblk; i++) begin
      blk = '0;
      for (int j = 0; j < r; j++) blk[8*j +: 8] = p[i*r + j];
      exp_q.push_back(blk);
      exp_last_q.push_back(i == nblk - 1);
      exp_cnt_q.push_back(8'(i + 1));
    end
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_blk(input string tag, input logic [BLK_W-1:0] obs, input logic [BLK_W-1:0] exp);
    int bad;
    bad = 0;
    for (int j = BLK_W/8 - 1; j >= 0; j--)
      if (obs[8*j +: 8] !== exp[8*j +: 8]) bad = j;
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: byte %0d observed 0x%0h expected 0x%0h", tag, bad, obs[8*bad +: 8], exp[8*bad +: 8]);
    end
  endtask

  // Driver: presents one word of msg_q with random garbage past the valid bytes
  task automatic drive_word(input int k, input int nw);
    int L;
    int b;
    L = msg_q.size();
    for (int j = 0; j < 8; j++)
      in_data[8*j +: 8] = (8*k + j < L) ? msg_q[8*k + j] : 8'($urandom_range(0, 255));
    in_last = (k == nw - 1);
    b = L - 8*k;
    if (k == nw - 1)
      in_bytes = (b == 8 && $urandom_range(0, 1) == 1) ? 4'($urandom_range(9, 15)) : 4'(b);
    else
      in_bytes = 4'($urandom_range(0, 15));
    in_valid = 1'b1;
  endtask

  // Streams msg_q with random gaps and random consumer stalls; checks every accepted block.
  task automatic run_msg(input logic [1:0] m);
    int nw;
    int widx;
    int cyc;
    bit go;
    nw = (msg_q.size() == 0) ? 1 : (msg_q.size() + 7) / 8;
    model_msg(m);
    widx = 0;
    cyc  = 0;
    go   = 1'b0;
    while ((widx < nw || exp_q.size() != 0) && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (go) begin
        widx++;
        in_valid = 1'b0;
      end
      mode = (widx == 0) ? m : 2'($urandom_range(0, 3));
      if (!in_valid && widx < nw && $urandom_range(0, 3) != 0) drive_word(widx, nw);
      blk_ready = ($urandom_range(0, 2) != 0);
      if (blk_valid && blk_ready && exp_q.size() != 0) begin
        chk_blk("blk_data", blk_data, exp_q.pop_front());
        chk("blk_last", blk_last, exp_last_q.pop_front());
        chk("blk_cnt", blk_cnt, exp_cnt_q.pop_front());
      end
      go = in_valid && in_ready;
    end
    chk("msg_done", exp_q.size(), 0);
    exp_q.delete();
    exp_last_q.delete();
    exp_cnt_q.delete();
    @(negedge clk);
    in_valid  = 1'b0;
    blk_ready = 1'b0;
    mode      = m;
    chk("idle_blk_valid", blk_valid, 0);
    chk("idle_blk_cnt", blk_cnt, 0);
    chk("idle_in_ready", in_ready, 1);
  endtask

  task automatic fill_random(input int len);
    msg_q.delete();
    for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom_range(0, 255)));
  endtask

  initial begin
    logic [BLK_W-1:0] exp_blk;
    logic [BLK_W-1:0] empty_blk;
    logic [1:0]       m;
    int               r;
    int               len;

    // Reset
    reset = 1'b1; mode = 2'b11; in_valid = 1'b0; in_data = '0;
    in_last = 1'b0; in_bytes = '0; blk_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_blk_valid", blk_valid, 0);
    chk("rst_blk_last", blk_last, 0);
    chk("rst_blk_cnt", blk_cnt, 0);
    chk_blk("rst_blk_data", blk_data, '0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);

    // Empty message, mode 11
    msg_q.delete();
    run_msg(2'b11);

    // "abc" with one-cycle latency, then 10 cycles of backpressure
    exp_blk = '0;
    exp_blk[63:0] = 64'h0000000006636261;
    exp_blk[135*8 +: 8] = 8'h80;
    empty_blk = '0;
    empty_blk[7:0] = 8'h06;
    empty_blk[135*8 +: 8] = 8'h80;
    @(negedge clk);
    mode = 2'b11; in_valid = 1'b1; in_data = 64'h0000000000636261;
    in_last = 1'b1; in_bytes = 4'd3; blk_ready = 1'b0;
    chk("abc_in_ready", in_ready, 1);
    @(negedge clk);
    in_data = {$urandom, $urandom}; in_last = 1'b1; in_bytes = 4'd0;
    chk("abc_latency", blk_valid, 1);
    chk_blk("abc_data", blk_data, exp_blk);
    chk("abc_last", blk_last, 1);
    chk("abc_cnt", blk_cnt, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk_blk("bp_data_stable", blk_data, exp_blk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_blk_valid", blk_valid, 1);
    end
    blk_ready = 1'b1;
    @(negedge clk);
    blk_ready = 1'b0;
    chk("rel_in_ready", in_ready, 1);
    chk("rel_blk_valid", blk_valid, 0);
    chk("rel_blk_cnt", blk_cnt, 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("held_word_latency", blk_valid, 1);
    chk_blk("held_word_data", blk_data, empty_blk);
    chk("held_word_cnt", blk_cnt, 1);
    blk_ready = 1'b1;
    @(negedge clk);
    blk_ready = 1'b0;
    chk("held_word_done", blk_valid, 0);

    // 135 bytes (0x86 byte) and 136 bytes (extra pad-only block), mode 11
    fill_random(135);
    run_msg(2'b11);
    fill_random(136);
    run_msg(2'b11);

    // Reset after 5 words of a mode-00 message, then "abc" in mode 10
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      mode = 2'b00; in_valid = 1'b1; in_data = {$urandom, $urandom};
      in_last = 1'b0; in_bytes = 4'd8;
    end
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_blk_valid", blk_valid, 0);
    chk("mid_rst_blk_cnt", blk_cnt, 0);
    chk_blk("mid_rst_blk_data", blk_data, '0);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready_again", in_ready, 1);
    msg_q.delete();
    msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63);
    run_msg(2'b10);

    // Random messages around rate boundaries in every mode
    for (int t = 0; t < 30; t++) begin
      m = 2'($urandom_range(0, 3));
      r = rate_bytes(m);
      case ($urandom_range(0, 4))
        0:       len = r - 1;
        1:       len = r;
        2:       len = r + 1;
        3:       len = 2 * r;
        default: len = $urandom_range(0, 300);
      endcase
      fill_random(len);
      run_msg(m);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/sha3_block_padder.md
Name: sha3_block_padder

Overview:
- Front-end feeder for the sha3 core. Accepts a message as a 64-bit little-endian word stream with valid/ready.
- Packs the words into rate-sized blocks and applies SHA-3 multi-rate padding: suffix 0x06 … final 0x80, or 0x86 when both land in the same byte.
- Presents each completed block on a 1152-bit output, held stable until accepted.
- The block output format matches the core's sha3_in word layout.

Parameters:
- W, 64: input word width in bits; fixed, only 64 supported.
- BLK_W, 1152: output block width; the maximum rate, used by SHA3-224.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- mode  in  2  00 = SHA3-512 (rate 72 B), 01 = 384 (104 B), 11 = 256 (136 B), 10 = 224 (144 B); sampled on the first word of each message
- in_valid  in  1  input word valid
- in_ready  out  1  padder can accept a word
- in_data  in  64  message word; byte k at bits [8k+7:8k]
- in_last  in  1  final word of the message
- in_bytes  in  4  valid bytes in the final word, 0..8; ignored unless in_last; values >8 treated as 8
- blk_valid  out  1  block available
- blk_ready  in  1  consumer accepts the block
- blk_data  out  1152  block; rate byte j at bits [8j+7:8j]; bits above the rate are 0
- blk_last  out  1  this block is the message's final (padded) block
- blk_cnt  out  8  number of blocks emitted for the current message, including the current one when blk_valid

Behaviour:
- Reset:
  - in_ready=0 during reset, then 1 on the cycle after reset drops.
  - blk_valid=0, blk_last=0, blk_data=0, blk_cnt=0.
  - State goes to FILL; word index = 0.
- Rate in words, R: 9 / 13 / 17 / 18 for modes 00 / 01 / 11 / 10. Mode is latched when word index=0 and no message is in progress; mode changes mid-message are ignored.
- FILL state:
  - in_ready=1.
  - On handshake, in_data is written to word slot idx; unwritten slots hold 0; idx increments.
  - Non-last word with idx+1==R → go to EMIT with blk_last=0.
  - in_last with in_bytes=b:
    - Bytes ≥ b of that word are zeroed.
    - Byte 8·idx+b of the block is XORed with 0x06.
    - If 8·idx+b < 8R, byte 8R−1 is XORed with 0x80 and the state goes to EMIT with blk_last=1.
    - If 8·idx+b == 8R (final word exactly fills the block), the state goes to EMIT with blk_last=0, then to PAD.
- PAD state:
  - Entered only after the block is accepted.
  - Builds an all-zero block with byte 0 = 0x06 and byte 8R−1 = 0x80, then goes to EMIT with blk_last=1.
  - in_ready=0.
- EMIT state:
  - blk_valid=1 and in_ready=0.
  - blk_data, blk_last and blk_cnt are stable while blk_valid && !blk_ready.
  - On blk_ready: the block buffer clears to 0 and idx clears to 0. Next state is PAD if the pending exact-fill flag is set, else FILL.
  - If blk_last was 1, blk_cnt clears to 0 on the following cycle.
- Latency:
  - The block is valid on the cycle after the handshake of the word that completes it.
  - The pad-only block is valid 2 cycles after the preceding block's acceptance.
- blk_cnt wraps from 255 to 0; no error is raised.
- Zero-length message: a single word with in_last=1, in_bytes=0 yields one block with byte 0=0x06 and byte 8R−1=0x80.
- in_ready is a registered output. No combinational path from in_valid to in_ready, or from blk_ready to blk_valid.
- Reset mid-message discards the partial block and any pending PAD, with no block emitted; the next word starts a new message with the mode resampled.
- in_valid asserted while in_ready=0: the word is not consumed, and the source must hold it.

Optional Feature:
- Macro: SHA3_PADDER_SHAKE_EN.
- When defined, an extra input port `xof` (1 bit) is added and latched with mode. When xof=1:
  - The domain suffix becomes 0x1F instead of 0x06.
  - Mode 11 selects SHAKE128, rate 168 B = 21 words. BLK_W grows to 1344 to hold it.
- When undefined: no xof port, suffix is always 0x06, BLK_W=1152.

Test Plan:
- Empty msg, mode 11: one word, in_last=1, in_bytes=0 → one block; byte0=0x06, byte135=0x80, all else 0; blk_last=1; blk_cnt=1.
- "abc" mode 11: in_data=0x0000000000636261, in_bytes=3, last → word0=0x0000000006636261, byte135=0x80, one block.
- 135-byte msg, mode 11 (16 full words, then in_bytes=7) → single block; byte134=msg, byte135=0x86; blk_last=1.
- 136-byte msg, mode 11 (17 full words, last on 17th) → block1 with blk_last=0 and no pad bytes; after acceptance, block2 = pad-only (byte0=0x06, byte135=0x80) with blk_last=1 and blk_cnt=2.
- Backpressure: hold blk_ready=0 for 10 cycles → blk_data constant, in_ready=0, no word consumed; then release → next word accepted the cycle after.
- Reset after 5 words of a mode-00 msg → outputs return to reset values; then an "abc" message in mode 10 gives byte143=0x80 and bits above 1151 zero.
